// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around past the highest index.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               any_o,
    output logic [IDW-1:0]     idx_o
);

    logic [IDW:0] cand;

    // Scan from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        any_o = |req_i;
        idx_o = ptr_i;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (req_i[cand[IDW-1:0]]) begin
                idx_o = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ requesters into one FIFO write port with
// bounded bursts. Define FIFO_ARB_CNT_EN to add per-requester transfer counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef FIFO_ARB_CNT_EN
    output logic [NUM_REQ*CNT_W-1:0]      grant_cnt,
`endif
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [IDW-1:0] IDX_LAST   = IDW'(NUM_REQ - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]  burst_q, burst_d;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           own_valid;
    logic           in_grant;
    logic           xfer;
    logic [IDW-1:0] data_sel;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Outputs are forced quiet while rst is high so a mid-burst reset writes nothing.
    assign own_valid     = req_valid[owner_q];
    assign in_grant      = !rst && (state_q == GRANT);
    assign xfer          = in_grant && own_valid && !fifo_full;
    assign fifo_write_en = xfer;
    assign busy          = in_grant;
    assign grant_id      = owner_q;
    assign data_sel      = rst ? '0 : owner_q;
    assign fifo_data_in  = req_data[data_sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        if (in_grant && !fifo_full) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    burst_d = '0;
                end
            end
            GRANT: begin
                // A full FIFO only stalls; losing valid is the sole release while stalled.
                if (!own_valid || (xfer && burst_q == BURST_LAST)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + IDW'(1);
                end else if (xfer) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating per-requester transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (xfer && (cnt_q[owner_q] != {CNT_W{1'b1}})) begin
            cnt_q[owner_q] <= cnt_q[owner_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule
